// File: rtl/cp_inserter_pkg.sv
// Shared OFDM constants and helpers for the cyclic-prefix inserter.
// Module parameters default to these values so alternate builds can override them.
package ofdm_pkg;

    localparam int N     = 8;
    localparam int CP    = 4;
    localparam int DW    = 32;
    localparam int LOG2N = $clog2(N);
    localparam int CNTW  = $clog2(N + CP);

    // Complex sample layout: real part in the upper half, imaginary in the lower half.
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    // Output beat number -> symbol sample index: the CP tail first, then the whole symbol.
    function automatic int cp_src_idx(input int rd, input int n, input int cp);
        return (rd < cp) ? (n - cp + rd) : (rd - cp);
    endfunction

endpackage

// File: rtl/cp_inserter_if.sv
// AXI-Stream style handshake bundle used on both sides of the CP inserter.
// tuser carries start-of-symbol on the output side and is unused on the input side.
interface cp_inserter_if #(
    parameter int DW = ofdm_pkg::DW
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/cp_inserter_pingpong_buf.sv
// Two N-deep sample banks: one synchronous write port, one asynchronous read port.
// Contents are not reset; the inserter's full flags decide what is meaningful.
module cp_pingpong_buf #(
    parameter int N  = ofdm_pkg::N,
    parameter int DW = ofdm_pkg::DW,
    parameter int AW = ofdm_pkg::LOG2N
) (
    input  logic          aclk,
    input  logic          i_wr_en,
    input  logic          i_wr_sel,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_sel,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    logic [1:0][DW-1:0] w_bank_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DW-1:0] r_mem [N];

        always_ff @(posedge aclk) begin
            if (i_wr_en && (i_wr_sel == 1'(b)))
                r_mem[i_wr_addr] <= i_wr_data;
        end

        assign w_bank_q[b] = r_mem[i_rd_addr];
    end

    assign o_rd_data = w_bank_q[i_rd_sel];

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: captures N-sample IFFT symbols into a ping-pong buffer and
// replays each one as its last CP samples followed by all N samples.
module cp_inserter #(
    parameter int N  = ofdm_pkg::N,
    parameter int CP = ofdm_pkg::CP,
    parameter int DW = ofdm_pkg::DW
) (
    input  logic         aclk,
    input  logic         aresetn,
    cp_inserter_if.slave  s_axis,
    cp_inserter_if.master m_axis,
    output logic         tlast_err
);
    import ofdm_pkg::*;

    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + CP);

    logic [AW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic [1:0]    r_full;
    logic          r_tlast_err;

    logic          w_s_ready;
    logic          w_s_hs;
    logic          w_wr_last;
    logic          w_m_valid;
    logic          w_m_hs;
    logic          w_rd_last;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_data;

    assign w_s_ready = ~r_full[r_wr_sel];
    assign w_s_hs    = s_axis.tvalid & w_s_ready;
    assign w_wr_last = (r_wr_cnt == AW'(N - 1));

    assign w_m_valid = r_full[r_rd_sel];
    assign w_m_hs    = w_m_valid & m_axis.tready;
    assign w_rd_last = (r_rd_cnt == CW'(N + CP - 1));
    assign w_rd_addr = AW'(cp_src_idx(int'(r_rd_cnt), N, CP));

    // Framing is judged purely by the write count; tlast never steers the data path.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_cnt    <= '0;
            r_wr_sel    <= 1'b0;
            r_tlast_err <= 1'b0;
        end else if (w_s_hs) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
            if (w_wr_last)
                r_wr_sel <= ~r_wr_sel;
            if (s_axis.tlast != w_wr_last)
                r_tlast_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_cnt <= '0;
            r_rd_sel <= 1'b0;
        end else if (w_m_hs) begin
            r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
            if (w_rd_last)
                r_rd_sel <= ~r_rd_sel;
        end
    end

    // A bank being filled is never full, a bank being drained always is, so set and
    // clear can never target the same bit in one cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_s_hs && w_wr_last && (r_wr_sel == 1'(b)))
                    r_full[b] <= 1'b1;
                else if (w_m_hs && w_rd_last && (r_rd_sel == 1'(b)))
                    r_full[b] <= 1'b0;
            end
        end
    end

    cp_pingpong_buf #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_buf (
        .aclk      (aclk),
        .i_wr_en   (w_s_hs),
        .i_wr_sel  (r_wr_sel),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (s_axis.tdata),
        .i_rd_sel  (r_rd_sel),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_m_valid ? w_rd_data : '0;
    assign m_axis.tuser  = w_m_valid & (r_rd_cnt == '0);
    assign m_axis.tlast  = w_m_valid & w_rd_last;
    assign tlast_err     = r_tlast_err;

    a_out_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (m_axis.tvalid && !m_axis.tready) |=>
        (m_axis.tvalid && $stable(m_axis.tdata) && $stable(m_axis.tlast) && $stable(m_axis.tuser)));

    a_rd_cnt_range: assert property (@(posedge aclk) disable iff (!aresetn)
        r_rd_cnt <= CW'(N + CP - 1));

endmodule
